// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin two-master Avalon-MM arbiter in front of one SDRAM controller port.
//   Ports:
//     clk, rst_n                    single clock and asynchronous active-low reset
//     m0_*, m1_*                    Avalon-MM slave ports facing the two masters
//     avalon_sdram_*                Avalon-MM master port facing the SDRAM controller
//     rd_orphan_o                   sticky flag, set when read data returns with no read outstanding
//   Read returns are steered to the issuing master through an in-order 1-bit ID FIFO.
module sdram_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter int BE_W       = 2,
  parameter int PEND_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_address_i,
  input  logic [BE_W-1:0]   m0_byteenable_n_i,
  input  logic [DATA_W-1:0] m0_writedata_i,
  input  logic              m0_read_n_i,
  input  logic              m0_write_n_i,
  output logic [DATA_W-1:0] m0_readdata_o,
  output logic              m0_readdatavalid_o,
  output logic              m0_waitrequest_o,
  input  logic [ADDR_W-1:0] m1_address_i,
  input  logic [BE_W-1:0]   m1_byteenable_n_i,
  input  logic [DATA_W-1:0] m1_writedata_i,
  input  logic              m1_read_n_i,
  input  logic              m1_write_n_i,
  output logic [DATA_W-1:0] m1_readdata_o,
  output logic              m1_readdatavalid_o,
  output logic              m1_waitrequest_o,
  output logic [ADDR_W-1:0] avalon_sdram_address_o,
  output logic [BE_W-1:0]   avalon_sdram_byteenable_n_o,
  output logic              avalon_sdram_chipselect_o,
  output logic [DATA_W-1:0] avalon_sdram_writedata_o,
  output logic              avalon_sdram_read_n_o,
  output logic              avalon_sdram_write_n_o,
  input  logic [DATA_W-1:0] avalon_sdram_readdata_i,
  input  logic              avalon_sdram_readdatavalid_i,
  input  logic              avalon_sdram_waitrequest_i,
  output logic              rd_orphan_o
);
  localparam int PW = $clog2(PEND_DEPTH);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, prio_q, prio_d;
  logic orphan_q;
  logic [PEND_DEPTH-1:0] fifo_q;
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0] cnt_q;
  logic rd0, rd1, wr0, wr1, el0, el1, full;
  logic own_rd, own_wr, blocked, active, accept, push, pop, head;
  // Both strobes low is treated as a write, so a read is only read_n low with write_n high.
  assign wr0 = ~m0_write_n_i;
  assign wr1 = ~m1_write_n_i;
  assign rd0 = ~m0_read_n_i & m0_write_n_i;
  assign rd1 = ~m1_read_n_i & m1_write_n_i;
  assign full = cnt_q == (PW+1)'(PEND_DEPTH);
  // A read that cannot issue does not compete for the port, so the other master's write can still proceed.
  assign el0 = wr0 | (rd0 & ~full);
  assign el1 = wr1 | (rd1 & ~full);
  assign own_rd = owner_q ? rd1 : rd0;
  assign own_wr = owner_q ? wr1 : wr0;
  assign blocked = own_rd & full;
  assign active = (state_q == BUSY) & ~blocked & (own_rd | own_wr);
  assign accept = active & ~avalon_sdram_waitrequest_i;
  assign push = accept & own_rd;
  assign pop = avalon_sdram_readdatavalid_i & (cnt_q != '0);
  assign head = fifo_q[rd_q];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d = accept ? ~owner_q : prio_q;
    if (state_q == IDLE) begin
      if (el0 | el1) begin
        state_d = BUSY;
        owner_d = (el0 & el1) ? prio_q : el1;
      end
    end else if (accept | ~(own_rd | own_wr)) begin
      state_d = IDLE;
    end
  end
  always_comb begin
    avalon_sdram_address_o      = active ? (owner_q ? m1_address_i : m0_address_i) : '0;
    avalon_sdram_writedata_o    = active ? (owner_q ? m1_writedata_i : m0_writedata_i) : '0;
    avalon_sdram_byteenable_n_o = active ? (owner_q ? m1_byteenable_n_i : m0_byteenable_n_i) : '1;
    avalon_sdram_chipselect_o   = active;
    avalon_sdram_read_n_o       = ~(active & own_rd);
    avalon_sdram_write_n_o      = ~(active & own_wr);
    m0_waitrequest_o            = ~(accept & ~owner_q);
    m1_waitrequest_o            = ~(accept & owner_q);
    m0_readdatavalid_o          = pop & ~head;
    m1_readdatavalid_o          = pop & head;
    m0_readdata_o               = avalon_sdram_readdata_i;
    m1_readdata_o               = avalon_sdram_readdata_i;
    rd_orphan_o                 = orphan_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      orphan_q <= 1'b0;
      fifo_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      owner_q <= owner_d;
      prio_q  <= prio_d;
      if (push) begin
        fifo_q[wr_q] <= owner_q;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      if (avalon_sdram_readdatavalid_i & (cnt_q == '0)) orphan_q <= 1'b1;
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed self-checking bench for sdram_arbiter.
module tb_sdram_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [23:0] m0_address, m1_address, s_address;
  logic [1:0] m0_be_n, m1_be_n, s_be_n;
  logic [15:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic m0_read_n, m0_write_n, m0_rdv, m0_wait;
  logic m1_read_n, m1_write_n, m1_rdv, m1_wait;
  logic s_cs, s_read_n, s_write_n, s_rdv, s_wait, orphan;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  sdram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_address_i(m0_address), .m0_byteenable_n_i(m0_be_n), .m0_writedata_i(m0_wdata),
    .m0_read_n_i(m0_read_n), .m0_write_n_i(m0_write_n), .m0_readdata_o(m0_rdata),
    .m0_readdatavalid_o(m0_rdv), .m0_waitrequest_o(m0_wait),
    .m1_address_i(m1_address), .m1_byteenable_n_i(m1_be_n), .m1_writedata_i(m1_wdata),
    .m1_read_n_i(m1_read_n), .m1_write_n_i(m1_write_n), .m1_readdata_o(m1_rdata),
    .m1_readdatavalid_o(m1_rdv), .m1_waitrequest_o(m1_wait),
    .avalon_sdram_address_o(s_address), .avalon_sdram_byteenable_n_o(s_be_n),
    .avalon_sdram_chipselect_o(s_cs), .avalon_sdram_writedata_o(s_wdata),
    .avalon_sdram_read_n_o(s_read_n), .avalon_sdram_write_n_o(s_write_n),
    .avalon_sdram_readdata_i(s_rdata), .avalon_sdram_readdatavalid_i(s_rdv),
    .avalon_sdram_waitrequest_i(s_wait), .rd_orphan_o(orphan)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    m0_address = '0; m0_be_n = '1; m0_wdata = '0; m0_read_n = 1'b1; m0_write_n = 1'b1;
    m1_address = '0; m1_be_n = '1; m1_wdata = '0; m1_read_n = 1'b1; m1_write_n = 1'b1;
    s_rdata = '0; s_rdv = 1'b0; s_wait = 1'b0;
    #2;
    chk("rst_m0_wait", m0_wait, 1);
    chk("rst_m1_wait", m1_wait, 1);
    chk("rst_cs", s_cs, 0);
    chk("rst_read_n", s_read_n, 1);
    chk("rst_write_n", s_write_n, 1);
    chk("rst_be_n", s_be_n, 2'b11);
    chk("rst_m0_rdv", m0_rdv, 0);
    chk("rst_orphan", orphan, 0);
    tick;
    rst_n = 1'b1;
    tick;
    // both masters read, prio 0: m0, then m1 (prio now 1) beats m0's second read
    m0_read_n = 1'b0; m0_address = 24'h000100;
    m1_read_n = 1'b0; m1_address = 24'h000200;
    #1;
    chk("rr_idle_m0_wait", m0_wait, 1);
    chk("rr_idle_cs", s_cs, 0);
    tick;
    chk("rr_g0_addr", s_address, 24'h000100);
    chk("rr_g0_read_n", s_read_n, 0);
    chk("rr_g0_m0_wait", m0_wait, 0);
    chk("rr_g0_m1_wait", m1_wait, 1);
    tick;
    m0_address = 24'h000101;
    #1;
    chk("rr_bubble_cs", s_cs, 0);
    tick;
    chk("rr_g1_addr", s_address, 24'h000200);
    chk("rr_g1_m1_wait", m1_wait, 0);
    chk("rr_g1_m0_wait", m0_wait, 1);
    tick;
    m1_read_n = 1'b1;
    #1;
    tick;
    chk("rr_g2_addr", s_address, 24'h000101);
    chk("rr_g2_m0_wait", m0_wait, 0);
    tick;
    m0_read_n = 1'b1;
    s_rdv = 1'b1; s_rdata = 16'h1111;
    #1;
    chk("ret1_m0_rdv", m0_rdv, 1);
    chk("ret1_m1_rdv", m1_rdv, 0);
    chk("ret1_m0_data", m0_rdata, 16'h1111);
    tick;
    s_rdata = 16'h2222;
    #1;
    chk("ret2_m1_rdv", m1_rdv, 1);
    chk("ret2_m0_rdv", m0_rdv, 0);
    chk("ret2_m1_data", m1_rdata, 16'h2222);
    tick;
    s_rdata = 16'h3333;
    #1;
    chk("ret3_m0_rdv", m0_rdv, 1);
    chk("ret3_m1_rdv", m1_rdv, 0);
    tick;
    s_rdv = 1'b0;
    #1;
    chk("ret_done_m0_rdv", m0_rdv, 0);
    chk("ret_done_orphan", orphan, 0);
    // single m0 write
    m0_write_n = 1'b0; m0_address = 24'h000010; m0_wdata = 16'hA5A5; m0_be_n = 2'b00;
    #1;
    chk("w0_idle_write_n", s_write_n, 1);
    tick;
    chk("w0_write_n", s_write_n, 0);
    chk("w0_cs", s_cs, 1);
    chk("w0_addr", s_address, 24'h000010);
    chk("w0_wdata", s_wdata, 16'hA5A5);
    chk("w0_be_n", s_be_n, 2'b00);
    chk("w0_m0_wait", m0_wait, 0);
    chk("w0_m1_wait", m1_wait, 1);
    tick;
    m0_write_n = 1'b1;
    #1;
    chk("w0_after_write_n", s_write_n, 1);
    chk("w0_after_cs", s_cs, 0);
    chk("w0_after_m0_wait", m0_wait, 1);
    chk("w0_after_addr", s_address, 0);
    chk("w0_after_wdata", s_wdata, 0);
    chk("w0_after_be_n", s_be_n, 2'b11);
    // m1 write stalled 5 cycles by the controller, m0 read waits
    s_wait = 1'b1;
    m1_write_n = 1'b0; m1_address = 24'h123456; m1_wdata = 16'hBEEF; m1_be_n = 2'b01;
    tick;
    m0_read_n = 1'b0; m0_address = 24'h000055;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_addr", s_address, 24'h123456);
      chk("stall_wdata", s_wdata, 16'hBEEF);
      chk("stall_be_n", s_be_n, 2'b01);
      chk("stall_write_n", s_write_n, 0);
      chk("stall_m1_wait", m1_wait, 1);
      chk("stall_m0_wait", m0_wait, 1);
      tick;
    end
    s_wait = 1'b0;
    #1;
    chk("stall_acc_m1_wait", m1_wait, 0);
    chk("stall_acc_m0_wait", m0_wait, 1);
    tick;
    m1_address = 24'h000777; m1_wdata = 16'h1234; m1_be_n = 2'b00;
    #1;
    chk("stall_bubble_cs", s_cs, 0);
    tick;
    chk("prio0_addr", s_address, 24'h000055);
    chk("prio0_read_n", s_read_n, 0);
    chk("prio0_m0_wait", m0_wait, 0);
    chk("prio0_m1_wait", m1_wait, 1);
    tick;
    m0_read_n = 1'b1;
    #1;
    tick;
    chk("m1_second_addr", s_address, 24'h000777);
    chk("m1_second_m1_wait", m1_wait, 0);
    tick;
    m1_write_n = 1'b1;
    s_rdv = 1'b1; s_rdata = 16'h0055;
    #1;
    chk("ret55_m0_rdv", m0_rdv, 1);
    chk("ret55_data", m0_rdata, 16'h0055);
    tick;
    s_rdv = 1'b0;
    // fill the ID FIFO with 8 reads
    m0_read_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m0_address = 24'(i);
      tick;
      chk("fill_m0_wait", m0_wait, 0);
      tick;
    end
    m0_address = 24'h000009;
    m1_write_n = 1'b0; m1_address = 24'h000099; m1_wdata = 16'h4242; m1_be_n = 2'b00;
    #1;
    chk("full_read_n", s_read_n, 1);
    chk("full_cs", s_cs, 0);
    chk("full_m0_wait", m0_wait, 1);
    tick;
    chk("full_m1_write_n", s_write_n, 0);
    chk("full_m1_addr", s_address, 24'h000099);
    chk("full_m1_wait", m1_wait, 0);
    chk("full_m0_wait2", m0_wait, 1);
    tick;
    m1_write_n = 1'b1;
    #1;
    chk("full_after_w_cs", s_cs, 0);
    tick;
    s_rdv = 1'b1; s_rdata = 16'h0000;
    #1;
    chk("full_pop_m0_rdv", m0_rdv, 1);
    chk("full_pop_read_n", s_read_n, 1);
    tick;
    s_rdv = 1'b0;
    #1;
    chk("unblock_same_read_n", s_read_n, 1);
    chk("unblock_same_m0_wait", m0_wait, 1);
    tick;
    chk("unblock_read_n", s_read_n, 0);
    chk("unblock_addr", s_address, 24'h000009);
    chk("unblock_m0_wait", m0_wait, 0);
    tick;
    m0_read_n = 1'b1;
    s_rdv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("drain_m0_rdv", m0_rdv, 1);
      tick;
    end
    s_rdv = 1'b0;
    #1;
    chk("drained_orphan", orphan, 0);
    // orphan return
    s_rdv = 1'b1; s_rdata = 16'hDEAD;
    #1;
    chk("orph_m0_rdv", m0_rdv, 0);
    chk("orph_m1_rdv", m1_rdv, 0);
    tick;
    s_rdv = 1'b0;
    #1;
    chk("orph_set", orphan, 1);
    tick;
    tick;
    chk("orph_sticky", orphan, 1);
    // reset mid-BUSY with 3 reads pending
    m0_read_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m0_address = 24'(i);
      tick;
      tick;
    end
    m0_read_n = 1'b1;
    s_wait = 1'b1;
    m1_write_n = 1'b0; m1_address = 24'h000ABC;
    tick;
    chk("pre_rst_write_n", s_write_n, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cs", s_cs, 0);
    chk("arst_write_n", s_write_n, 1);
    chk("arst_addr", s_address, 0);
    chk("arst_be_n", s_be_n, 2'b11);
    chk("arst_m1_wait", m1_wait, 1);
    chk("arst_orphan", orphan, 0);
    m1_write_n = 1'b1;
    s_wait = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    s_rdv = 1'b1;
    #1;
    chk("post_rst_m0_rdv", m0_rdv, 0);
    chk("post_rst_m1_rdv", m1_rdv, 0);
    tick;
    s_rdv = 1'b0;
    #1;
    chk("post_rst_orphan", orphan, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-master Avalon-MM arbiter sharing the single `sdram` controller port between the UART command processor (master 0) and a second requester (master 1, e.g. a pattern tester). Sits between the masters and the controller's `avalon_sdram_*` slave interface in the `sys_clk` domain. Round-robin grant per transfer. Pipelined reads are routed back to the issuing master through an in-order ID FIFO.

## Interface
- `ADDR_W`, 24, address width.
- `DATA_W`, 16, data width.
- `BE_W`, 2, byte-enable width.
- `PEND_DEPTH`, 8, max outstanding reads; power of 2, ≥2.
- `clk` in 1: the single clock, `sys_clk`. The block has one clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `mN_address` in ADDR_W (N = 0, 1): master N word address.
- `mN_byteenable_n` in BE_W: active-low byte enables.
- `mN_writedata` in DATA_W: write data.
- `mN_read_n` in 1: active-low read request.
- `mN_write_n` in 1: active-low write request.
- `mN_readdata` out DATA_W: read data.
- `mN_readdatavalid` out 1: read data valid for master N.
- `mN_waitrequest` out 1: stall to master N.
- `avalon_sdram_address` out ADDR_W: address to the controller.
- `avalon_sdram_byteenable_n` out BE_W: byte enables to the controller.
- `avalon_sdram_chipselect` out 1: chip select.
- `avalon_sdram_writedata` out DATA_W: write data to the controller.
- `avalon_sdram_read_n` out 1: read request to the controller.
- `avalon_sdram_write_n` out 1: write request to the controller.
- `avalon_sdram_readdata` in DATA_W: read data from the controller.
- `avalon_sdram_readdatavalid` in 1: read data valid from the controller.
- `avalon_sdram_waitrequest` in 1: stall from the controller.
- `rd_orphan` out 1: sticky flag. Set when `readdatavalid` arrives with the ID FIFO empty.

## Operation
- Request: `reqN = ~mN_read_n | ~mN_write_n`. If both are low, the request is treated as a write (illegal master behaviour).
- Registered state: `state` {IDLE, BUSY}, `owner`, `prio`, and the ID FIFO (PEND_DEPTH entries × 1 bit, with a count of width log2(PEND_DEPTH)+1).
- IDLE:
  - If no request, stay in IDLE.
  - If exactly one `reqN`, latch `owner=N` and go to BUSY.
  - If both request, `owner=prio` and go to BUSY.
- BUSY: the slave port drives `owner`'s address, byteenable_n, writedata, read_n and write_n, with `chipselect=1`.
- Read in BUSY with FIFO full: `avalon_sdram_read_n` is held 1 and chipselect 0. No read is issued until the count drops.
- Accept: slave request asserted and `avalon_sdram_waitrequest=0`. On accept:
  - Return to IDLE.
  - Set `prio=~owner`.
  - For a read, push `owner` into the FIFO.
- Throughput: at most one transfer per 2 cycles, due to the IDLE bubble.
- Master waitrequest: `mN_waitrequest=0` only in the cycle owner=N is accepted by the slave; otherwise 1. This includes IDLE, a non-owner master, and a blocked read.
- Read return: on `avalon_sdram_readdatavalid`, pop the FIFO head and assert `m<head>_readdatavalid` combinationally in the same cycle.
  - `m0_readdata` and `m1_readdata` both equal `avalon_sdram_readdata`.
  - If the FIFO is empty, neither valid is asserted and `rd_orphan` is set.
- Simultaneous push and pop: count unchanged and both take effect. Full-blocking uses the registered count, so a pop in the same cycle does not unblock that cycle.
- Idle slave outputs (IDLE or blocked): address 0, writedata 0, byteenable_n all-ones, read_n=1, write_n=1, chipselect=0.
- Reset values: state IDLE, owner 0, prio 0, FIFO empty, `rd_orphan` 0. All slave outputs take their idle values. `mN_waitrequest=1` and `mN_readdatavalid=0`.
- Reset mid-operation: all in-flight state is discarded immediately. The controller shares `rst_n`, so no late returns are expected. Any that do arrive set `rd_orphan`.

## Timing
- Grant latency: request seen in cycle T gives slave signals driven in T+1. Earliest `mN_waitrequest=0` is T+1 if the controller does not stall.
- The owner's signals must stay stable while `mN_waitrequest=1`, per Avalon rules. The arbiter never changes `owner` in BUSY.
- Read data path is zero-latency and combinational from the controller to the master, in issue order.
- Writes are never blocked by FIFO state.

## Test plan
- Single master 0 write, addr 0x000010, data 0xA5A5, controller waitrequest low → slave write_n=0 one cycle later, `m0_waitrequest` low for exactly that cycle, then IDLE.
- Both masters request reads in the same cycle with prio=0 → m0 is served first, then m1. With readdatavalid returning 0x1111 then 0x2222, m0 gets 0x1111 and m1 gets 0x2222. prio ends at 0.
- Controller holds waitrequest high for 5 cycles during an m1 write → slave signals stay constant, `m1_waitrequest` is high throughout, and m0's request is not granted until after acceptance.
- PEND_DEPTH=8 reads issued with no readdatavalid → the 9th read is held (read_n=1, `m0_waitrequest`=1). One readdatavalid frees it, and it issues no earlier than the next cycle. A write from m1 proceeds while reads are blocked.
- readdatavalid pulse with empty FIFO → no master valid, `rd_orphan`=1 and stays set until `rst_n` is low.
- Assert `rst_n` low mid-BUSY with 3 reads pending → all outputs take reset values asynchronously and the FIFO count is 0 after release.
